// File: rtl/mult_seq_ctrl_pkg.sv
// Shared types for the multiply-slot sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_ctrl_pkg;

  localparam int MUL_LATENCY_MAX = 255;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PUBLISH = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and register-enable bundle between the sequencer and the multiplier slot.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry it; the bundle itself adds none.
interface mult_seq_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic a_we;
  logic b_we;
  logic a_re;
  logic b_re;
  logic p_we;
  logic p_re;
  logic out_valid;
  logic out_ready;

  // Sequencer side
  modport master (
    input  in_valid, out_ready,
    output in_ready, a_we, b_we, a_re, b_re, p_we, p_re, out_valid
  );

  // Operand source / result consumer / register side
  modport slave (
    output in_valid, out_ready,
    input  in_ready, a_we, b_we, a_re, b_re, p_we, p_re, out_valid
  );

endinterface

// File: rtl/mult_lat_counter.sv
// Loadable 8-bit down-counter timing the multiplier core latency.
// Latency: load/decrement visible one cycle after the enabling edge; zero is combinational from the count.
// Backpressure: none; holds its value when neither load nor en is set.
module mult_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Load wins over decrement so a fresh operation always starts from a known count
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Count register, cleared by the async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequences one multiply: load A/B, read them into the core, wait MUL_LATENCY, capture and publish P.
// Latency: out_valid rises in the cycle after accept edge + 3 + MUL_LATENCY.
// Backpressure: product held with out_valid until out_ready; in_ready low for the whole operation.
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  mult_seq_ctrl_if.master    bus,
  input  logic               abort,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  if (MUL_LATENCY < 1 || MUL_LATENCY > MUL_LATENCY_MAX) begin : g_bad_latency
    $error("mult_seq_ctrl: MUL_LATENCY must lie in 1..255");
  end

  localparam logic [7:0] LAT_LOAD = 8'(MUL_LATENCY - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;

  logic cnt_load;
  logic cnt_en;
  logic cnt_zero;

  logic in_ready;
  logic out_valid;
  logic a_we;
  logic b_we;
  logic a_re;
  logic b_re;
  logic p_we;
  logic p_re;

  mult_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero)
  );

  // Next state, register enables and completion count; abort then reset override last
  always_comb begin
    state_d    = state_q;
    op_count_d = op_count_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    a_re       = 1'b0;
    b_re       = 1'b0;
    p_we       = 1'b0;
    p_re       = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        a_we     = bus.in_valid;
        b_we     = bus.in_valid;
        if (bus.in_valid) state_d = ST_READ;
      end
      ST_READ: begin
        // Operands were written last cycle; a read-only cycle moves them to dataOut
        a_re     = 1'b1;
        b_re     = 1'b1;
        cnt_load = 1'b1;
        state_d  = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (cnt_zero) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_CAPTURE: begin
        p_we    = 1'b1;
        state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        p_re    = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel drops the operation without touching any register or the count
    if (abort) begin
      state_d    = ST_IDLE;
      op_count_d = op_count_q;
      a_we       = 1'b0;
      b_we       = 1'b0;
      a_re       = 1'b0;
      b_re       = 1'b0;
      p_we       = 1'b0;
      p_re       = 1'b0;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
    end

    // State sits in IDLE during reset, so the IDLE decode must be masked here
    if (reset) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      a_we      = 1'b0;
      b_we      = 1'b0;
      a_re      = 1'b0;
      b_re      = 1'b0;
      p_we      = 1'b0;
      p_re      = 1'b0;
    end
  end

  // State and completion-count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.a_we      = a_we;
  assign bus.b_we      = b_we;
  assign bus.a_re      = a_re;
  assign bus.b_re      = b_re;
  assign bus.p_we      = p_we;
  assign bus.p_re      = p_re;
  assign busy          = (state_q != ST_IDLE);
  assign op_count      = op_count_q;

endmodule
